// File: rtl/cfa_diag_window.sv
// Diagonal 3x3 neighbourhood generator for the G and RB planes; 1-clk latency, no back-pressure.
// Optional macro CFA_DIAG_WIN_CENTER_EN adds centre-sample outputs G_c / RB_c.
module cfa_diag_window #(
    parameter int DataBitWidth = 12,
    parameter int ImgWidth     = 640,
    parameter int ImgHeight    = 480,
    parameter int ColBits      = 10,
    parameter int RowBits      = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sof,
    input  logic                    in_valid,
    input  logic [DataBitWidth-1:0] G_in,
    input  logic [DataBitWidth-1:0] RB_in,
    output logic [DataBitWidth-1:0] G_m1_m1,
    output logic [DataBitWidth-1:0] G_m1_p1,
    output logic [DataBitWidth-1:0] G_p1_m1,
    output logic [DataBitWidth-1:0] G_p1_p1,
    output logic [DataBitWidth-1:0] RB_m1_m1,
    output logic [DataBitWidth-1:0] RB_m1_p1,
    output logic [DataBitWidth-1:0] RB_p1_m1,
    output logic [DataBitWidth-1:0] RB_p1_p1,
    output logic                    out_valid,
    output logic                    row_odd,
    output logic                    col_odd
`ifdef CFA_DIAG_WIN_CENTER_EN
    ,
    output logic [DataBitWidth-1:0] G_c,
    output logic [DataBitWidth-1:0] RB_c
`endif
);

    typedef enum logic [1:0] {IDLE, FILL, ACTIVE} state_t;

    localparam logic [ColBits-1:0] COL_LAST = ColBits'(ImgWidth - 1);
    localparam logic [RowBits-1:0] ROW_LAST = RowBits'(ImgHeight - 1);

    state_t               state_q;
    logic [ColBits-1:0]   col_q;
    logic [RowBits-1:0]   row_q;

    logic [DataBitWidth-1:0] g_lb1 [ImgWidth];
    logic [DataBitWidth-1:0] g_lb2 [ImgWidth];
    logic [DataBitWidth-1:0] rb_lb1 [ImgWidth];
    logic [DataBitWidth-1:0] rb_lb2 [ImgWidth];

    // Index 0 holds column c-1, index 1 holds column c-2 of the tapped row.
    logic [1:0][DataBitWidth-1:0] g_cur_q, rb_cur_q, g_top_q, rb_top_q;

    logic [DataBitWidth-1:0] g_m1_m1_q, g_m1_p1_q, g_p1_m1_q, g_p1_p1_q;
    logic [DataBitWidth-1:0] rb_m1_m1_q, rb_m1_p1_q, rb_p1_m1_q, rb_p1_p1_q;
    logic                    out_valid_q, row_odd_q, col_odd_q;

    logic                    accept, emit;
    logic [ColBits-1:0]      col_cur;
    logic [DataBitWidth-1:0] g_rd1, g_rd2, rb_rd1, rb_rd2;

    assign accept  = in_valid && (sof || (state_q != IDLE));
    assign col_cur = sof ? '0 : col_q;
    // A sof pixel is (0,0), so it can never be a window corner.
    assign emit    = accept && !sof && (state_q == ACTIVE) && (col_q >= ColBits'(2));

    assign g_rd1  = g_lb1[col_cur];
    assign g_rd2  = g_lb2[col_cur];
    assign rb_rd1 = rb_lb1[col_cur];
    assign rb_rd2 = rb_lb2[col_cur];

    always_ff @(posedge clk) begin
        if (accept) begin
            g_lb2[col_cur]  <= g_rd1;
            g_lb1[col_cur]  <= G_in;
            rb_lb2[col_cur] <= rb_rd1;
            rb_lb1[col_cur] <= RB_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
        end else if (accept) begin
            if (sof) begin
                state_q <= FILL;
                row_q   <= '0;
                col_q   <= ColBits'(1);
            end else if (col_q == COL_LAST) begin
                col_q <= '0;
                if (row_q == ROW_LAST) begin
                    row_q   <= '0;
                    state_q <= IDLE;
                end else begin
                    row_q <= row_q + RowBits'(1);
                    if (row_q == RowBits'(1)) state_q <= ACTIVE;
                end
            end else begin
                col_q <= col_q + ColBits'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            g_cur_q  <= '0;
            rb_cur_q <= '0;
            g_top_q  <= '0;
            rb_top_q <= '0;
        end else if (accept) begin
            g_cur_q  <= {g_cur_q[0], G_in};
            rb_cur_q <= {rb_cur_q[0], RB_in};
            g_top_q  <= {g_top_q[0], g_rd2};
            rb_top_q <= {rb_top_q[0], rb_rd2};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            g_m1_m1_q   <= '0;
            g_m1_p1_q   <= '0;
            g_p1_m1_q   <= '0;
            g_p1_p1_q   <= '0;
            rb_m1_m1_q  <= '0;
            rb_m1_p1_q  <= '0;
            rb_p1_m1_q  <= '0;
            rb_p1_p1_q  <= '0;
            out_valid_q <= 1'b0;
            row_odd_q   <= 1'b0;
            col_odd_q   <= 1'b0;
        end else begin
            out_valid_q <= emit;
            if (emit) begin
                g_m1_m1_q  <= g_top_q[1];
                g_m1_p1_q  <= g_rd2;
                g_p1_m1_q  <= g_cur_q[1];
                g_p1_p1_q  <= G_in;
                rb_m1_m1_q <= rb_top_q[1];
                rb_m1_p1_q <= rb_rd2;
                rb_p1_m1_q <= rb_cur_q[1];
                rb_p1_p1_q <= RB_in;
                row_odd_q  <= ~row_q[0];
                col_odd_q  <= ~col_q[0];
            end
        end
    end

`ifdef CFA_DIAG_WIN_CENTER_EN
    logic [DataBitWidth-1:0] g_mid_q, rb_mid_q, g_c_q, rb_c_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            g_mid_q  <= '0;
            rb_mid_q <= '0;
            g_c_q    <= '0;
            rb_c_q   <= '0;
        end else begin
            if (accept) begin
                g_mid_q  <= g_rd1;
                rb_mid_q <= rb_rd1;
            end
            if (emit) begin
                g_c_q  <= g_mid_q;
                rb_c_q <= rb_mid_q;
            end
        end
    end

    assign G_c  = g_c_q;
    assign RB_c = rb_c_q;
`endif

    assign G_m1_m1   = g_m1_m1_q;
    assign G_m1_p1   = g_m1_p1_q;
    assign G_p1_m1   = g_p1_m1_q;
    assign G_p1_p1   = g_p1_p1_q;
    assign RB_m1_m1  = rb_m1_m1_q;
    assign RB_m1_p1  = rb_m1_p1_q;
    assign RB_p1_m1  = rb_p1_m1_q;
    assign RB_p1_p1  = rb_p1_p1_q;
    assign out_valid = out_valid_q;
    assign row_odd   = row_odd_q;
    assign col_odd   = col_odd_q;

endmodule

// File: doc/cfa_diag_window.md
Name: cfa_diag_window

Overview:
- Neighbourhood generator directly upstream of the diagonal RB-interpolation stage (pre-equation 24/27 path).
- Accepts a raster stream of interpolated-G and raw Bayer R/B samples.
- Buffers two image lines of each plane and presents the four diagonal neighbours of the current centre pixel per plane, with a valid strobe and the centre's Bayer phase.

Parameters:
- DataBitWidth, 12, bits per G and RB sample
- ImgWidth, 640, pixels per line (line-buffer depth), minimum 4
- ImgHeight, 480, lines per frame, minimum 3
- ColBits, 10, column counter width, must satisfy 2**ColBits >= ImgWidth
- RowBits, 9, row counter width, must satisfy 2**RowBits >= ImgHeight

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- sof  in  1  start of frame; qualified by in_valid; marks pixel (0,0)
- in_valid  in  1  G_in/RB_in valid this cycle
- G_in  in  DataBitWidth  interpolated green sample
- RB_in  in  DataBitWidth  raw Bayer sample (R, B or G site)
- G_m1_m1, G_m1_p1, G_p1_m1, G_p1_p1  out  DataBitWidth each  G at centre (-1,-1), (-1,+1), (+1,-1), (+1,+1)
- RB_m1_m1, RB_m1_p1, RB_p1_m1, RB_p1_p1  out  DataBitWidth each  RB at the same offsets
- out_valid  out  1  window outputs valid, one-cycle strobe per centre
- row_odd, col_odd  out  1 each  LSB of the centre's row and column

Behaviour:
- Reset: all outputs 0, counters 0, FSM IDLE. Line-buffer contents are not reset; they are never output before being overwritten.
- Accepted input pixel (r,c): in_valid=1 in state FILL or ACTIVE.
- Counters: col increments per accepted pixel and wraps ImgWidth-1 -> 0 with row+1. Row wraps ImgHeight-1 -> 0 at the last pixel of the frame, with FSM -> IDLE.
- sof with in_valid, in any state: that pixel is (0,0); counters restart; FSM -> FILL. This restarts a frame cleanly even mid-frame.
- FSM states:
  - IDLE: ignore in_valid without sof; exit only on sof.
  - FILL: rows 0-1 are written to the line buffers; no output. -> ACTIVE when row becomes 2.
  - ACTIVE: rows 2..ImgHeight-1.
- Line buffers: two per plane (row r-1, row r-2), ImgWidth entries each, addressed by col. Read-before-write in the same cycle: row r-1 line cascades into row r-2 line; the input goes into row r-1 line.
- Horizontal taps: 3-deep shift registers on the current row and the row r-2 read data, per plane. They advance only on accepted pixels and hold during in_valid=0 gaps.
- Window centre = (r-1, c-1).
- Diagonal mapping:
  - m1_m1 = (r-2, c-2)
  - m1_p1 = (r-2, c)
  - p1_m1 = (r, c-2)
  - p1_p1 = (r, c)
- Output condition: out_valid=1 exactly one cycle after an accepted pixel with FSM ACTIVE (r>=2) and c>=2. Otherwise out_valid=0 and data outputs hold their last value.
- Latency 1 clk; no back-pressure, throughput 1 pixel/clk.
- Output count per frame: (ImgHeight-2)*(ImgWidth-2). Border centres (row/col 0 and last) produce no output.
- row_odd = (r-1)[0], col_odd = (c-1)[0], registered with the data.
- Reset asserted mid-frame: all outputs clear immediately, out_valid=0; a new sof is required.

Optional Feature:
- CFA_DIAG_WIN_CENTER_EN.
- Defined: extra outputs G_c and RB_c (DataBitWidth each) carry the centre sample (r-1, c-1), taken from the row r-1 line buffer through a 2-deep tap, aligned with out_valid. Both reset to 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Bench parameters: ImgWidth=8, ImgHeight=6. Stimulus G_in = 16*r+c, RB_in = 0x800 + 16*r+c.
- Continuous frame:
  - First out_valid the cycle after pixel (2,2), with G_m1_m1=0x00, G_m1_p1=0x02, G_p1_m1=0x20, G_p1_p1=0x22, RB_m1_m1=0x800, RB_p1_p1=0x822, row_odd=1, col_odd=1.
  - Exactly 24 strobes per frame.
- in_valid gaps: random 0-3 idle cycles between pixels -> identical data sequence and 24 strobes; out_valid never high during a gap except the cycle after the accepted pixel.
- Pixels before first sof / after frame end: drive 10 in_valid pixels with sof=0 from reset -> no out_valid. Then a frame with sof -> matches the continuous case.
- sof at pixel (3,4) of frame 1: new frame restarts; no out_valid until new pixel (2,2), whose window equals the continuous-case values.
- Reset mid-frame: rst low at pixel (3,5) -> out_valid and all outputs 0 immediately; after release with sof=0 -> nothing. Next sof frame is correct.
- With CFA_DIAG_WIN_CENTER_EN: at the first strobe G_c=0x11, RB_c=0x811. Last strobe of frame: G_c=0x46, G_p1_p1=0x57.
